// File: rtl/rf_write_arbiter_if.sv
// Register-file write-port bundle: pipeline writeback (wb0), multicycle writeback (wb1),
// issue notifications and the resulting write port / scoreboard / status outputs.
interface rf_write_arbiter_if;
    logic        wb0_valid;
    logic [4:0]  wb0_rd;
    logic [31:0] wb0_data;
    logic        wb1_valid;
    logic [4:0]  wb1_rd;
    logic [31:0] wb1_data;
    logic        wb1_ready;
    logic        iss_valid;
    logic [4:0]  iss_rd;
    logic        rf_we;
    logic [4:0]  rf_wa;
    logic [31:0] rf_wd;
    logic [31:0] busy;
    logic        stall_o;
    logic        protocol_err;

    modport master (
        output wb0_valid, wb0_rd, wb0_data,
        output wb1_valid, wb1_rd, wb1_data,
        output iss_valid, iss_rd,
        input  wb1_ready, rf_we, rf_wa, rf_wd, busy, stall_o, protocol_err
    );

    modport slave (
        input  wb0_valid, wb0_rd, wb0_data,
        input  wb1_valid, wb1_rd, wb1_data,
        input  iss_valid, iss_rd,
        output wb1_ready, rf_we, rf_wa, rf_wd, busy, stall_o, protocol_err
    );
endinterface

// File: rtl/rf_write_arbiter.sv
// Single write-port arbiter (wb0 priority) with multicycle scoreboard and protocol checker.
// Define RF_ARB_STARVE_GUARD_EN to compile in the wb1 starvation guard (stall_o).
module rf_write_arbiter #(
    parameter int STARVE_LIMIT = 4
) (
    input logic           clk,
    input logic           rst,
    rf_write_arbiter_if.slave bus
);

    if (STARVE_LIMIT < 1 || STARVE_LIMIT > 15) begin : g_bad_limit
        $error("STARVE_LIMIT must be in 1..15");
    end

    logic        wb0_own;
    logic        wb1_req;
    logic        wb1_ready_c;
    logic        wb1_hs;
    logic [31:1] busy_hi;
    logic [31:0] busy_vec;
    logic        stall_reg;
    logic        err_stall;
    logic        err_iss;
    logic        err_wb1;
    logic        protocol_err_reg;

    assign wb0_own  = bus.wb0_valid && (bus.wb0_rd != 5'd0);
    assign wb1_req  = bus.wb1_valid && (bus.wb1_rd != 5'd0);
    assign busy_vec = {busy_hi, 1'b0};

    // Grant is purely combinational; reset masks every output handshake immediately.
    always_comb begin
        wb1_ready_c = 1'b0;
        bus.rf_we   = 1'b0;
        bus.rf_wa   = 5'd0;
        bus.rf_wd   = 32'd0;
        if (!rst) begin
            wb1_ready_c = bus.wb1_valid && ((bus.wb1_rd == 5'd0) || !wb0_own);
            if (wb0_own) begin
                bus.rf_we = 1'b1;
                bus.rf_wa = bus.wb0_rd;
                bus.rf_wd = bus.wb0_data;
            end else if (wb1_req) begin
                bus.rf_we = 1'b1;
                bus.rf_wa = bus.wb1_rd;
                bus.rf_wd = bus.wb1_data;
            end
        end
    end

    assign wb1_hs        = bus.wb1_valid && wb1_ready_c;
    assign bus.wb1_ready = wb1_ready_c;

    genvar gi;
    generate
        for (gi = 1; gi < 32; gi++) begin : g_busy
            logic set_bit;
            logic clr_bit;
            assign set_bit = bus.iss_valid && (bus.iss_rd == 5'(gi));
            assign clr_bit = wb1_hs && (bus.wb1_rd == 5'(gi));
            // An issue landing on the same edge as the retiring writeback re-arms the bit.
            always_ff @(posedge clk or posedge rst) begin
                if (rst)          busy_hi[gi] <= 1'b0;
                else if (set_bit) busy_hi[gi] <= 1'b1;
                else if (clr_bit) busy_hi[gi] <= 1'b0;
            end
        end
    endgenerate

    assign bus.busy = busy_vec;

`ifdef RF_ARB_STARVE_GUARD_EN
    localparam logic [3:0] STALL_AT = 4'(STARVE_LIMIT - 1);

    logic [3:0] wait_cnt_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wait_cnt_reg <= 4'd0;
            stall_reg    <= 1'b0;
        end else if (!bus.wb1_valid || wb1_hs) begin
            wait_cnt_reg <= 4'd0;
            stall_reg    <= 1'b0;
        end else begin
            if (wait_cnt_reg != 4'hF) wait_cnt_reg <= wait_cnt_reg + 4'd1;
            if (wait_cnt_reg == STALL_AT) stall_reg <= 1'b1;
        end
    end

    assign err_stall = wb0_own && stall_reg;
`else
    assign stall_reg = 1'b0;
    assign err_stall = 1'b0;
`endif

    assign bus.stall_o = stall_reg;

    assign err_iss = bus.iss_valid && (bus.iss_rd != 5'd0) && busy_vec[bus.iss_rd];
    assign err_wb1 = wb1_hs && (bus.wb1_rd != 5'd0) && !busy_vec[bus.wb1_rd];

    always_ff @(posedge clk or posedge rst) begin
        if (rst)                                protocol_err_reg <= 1'b0;
        else if (err_iss || err_wb1 || err_stall) protocol_err_reg <= 1'b1;
    end

    assign bus.protocol_err = protocol_err_reg;

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Bench for rf_write_arbiter: directed vectors, a rule-level model compared every cycle,
// plus hand-computed literal expectations at key points.
module tb_rf_write_arbiter;
    localparam int LIMIT = 4;
`ifdef RF_ARB_STARVE_GUARD_EN
    localparam bit GUARD = 1'b1;
`else
    localparam bit GUARD = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    rf_write_arbiter_if bus();

    rf_write_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;

    // Model state: which registers await a result, how long wb1 has waited, flags.
    logic [31:0] m_busy  = 32'd0;
    int          m_wait  = 0;
    bit          m_stall = 1'b0;
    bit          m_err   = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Owner of the write port: 0 = wb0, 1 = wb1, -1 = nobody.
    function automatic int owner();
        if (rst) return -1;
        if (bus.wb0_valid && bus.wb0_rd != 0) return 0;
        if (bus.wb1_valid && bus.wb1_rd != 0) return 1;
        return -1;
    endfunction

    function automatic bit exp_ready();
        return !rst && bus.wb1_valid && (bus.wb1_rd == 0 || owner() != 0);
    endfunction

    function automatic logic [31:0] next_busy(input logic [31:0] b);
        logic [31:0] r;
        r = b;
        if (bus.wb1_valid && exp_ready() && bus.wb1_rd != 0) r = r & ~(32'd1 << bus.wb1_rd);
        if (bus.iss_valid && bus.iss_rd != 0) r = r | (32'd1 << bus.iss_rd);
        return r;
    endfunction

    function automatic bit violation();
        bit hs;
        hs = bus.wb1_valid && exp_ready();
        if (bus.iss_valid && bus.iss_rd != 0 && m_busy[bus.iss_rd]) return 1'b1;
        if (hs && bus.wb1_rd != 0 && !m_busy[bus.wb1_rd]) return 1'b1;
        if (GUARD && m_stall && bus.wb0_valid && bus.wb0_rd != 0) return 1'b1;
        return 1'b0;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_busy  <= 32'd0;
            m_wait  <= 0;
            m_stall <= 1'b0;
            m_err   <= 1'b0;
        end else begin
            m_busy <= next_busy(m_busy);
            if (violation()) m_err <= 1'b1;
            if (!bus.wb1_valid || exp_ready()) begin
                m_wait  <= 0;
                m_stall <= 1'b0;
            end else begin
                m_wait <= (m_wait >= 15) ? 15 : m_wait + 1;
                if (GUARD && m_wait == LIMIT - 1) m_stall <= 1'b1;
            end
        end
    end

    always @(negedge clk) begin
        int o;
        o = owner();
        chk("m_rf_we", 32'(bus.rf_we), 32'(o >= 0));
        chk("m_rf_wa", 32'(bus.rf_wa), (o == 0) ? 32'(bus.wb0_rd) : (o == 1) ? 32'(bus.wb1_rd) : 32'd0);
        chk("m_rf_wd", bus.rf_wd, (o == 0) ? bus.wb0_data : (o == 1) ? bus.wb1_data : 32'd0);
        chk("m_wb1_ready", 32'(bus.wb1_ready), 32'(exp_ready()));
        chk("m_busy", bus.busy, m_busy);
        chk("m_stall", 32'(bus.stall_o), 32'(m_stall));
        chk("m_perr", 32'(bus.protocol_err), 32'(m_err));
    end

    task automatic set_in(input bit w0v, input logic [4:0] w0rd, input logic [31:0] w0d,
                          input bit w1v, input logic [4:0] w1rd, input logic [31:0] w1d,
                          input bit iv, input logic [4:0] ird);
        bus.wb0_valid = w0v; bus.wb0_rd = w0rd; bus.wb0_data = w0d;
        bus.wb1_valid = w1v; bus.wb1_rd = w1rd; bus.wb1_data = w1d;
        bus.iss_valid = iv;  bus.iss_rd = ird;
    endtask

    task automatic idle();
        set_in(0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic at_neg();
        @(negedge clk);
    endtask

    task automatic rst_pulse();
        rst = 1'b1;
        idle();
        at_neg();
        chk("rst_busy", bus.busy, 32'd0);
        chk("rst_perr", 32'(bus.protocol_err), 32'd0);
        tick();
        rst = 1'b0;
    endtask

    // Four cycles of wb1 blocked by a busy pipeline.
    task automatic starve();
        for (int i = 0; i < 4; i++) begin
            set_in(1, 2, 32'h2000 + i, 1, 4, 32'hC4, 0, 0);
            at_neg();
            chk("starve_ready", 32'(bus.wb1_ready), 32'd0);
            chk("starve_stall", 32'(bus.stall_o), 32'd0);
            tick();
        end
    endtask

    initial begin
        rst = 1'b1;
        idle();
        repeat (2) tick();
        set_in(1, 5, 32'hAA, 1, 6, 32'hBB, 1, 3);
        at_neg();
        chk("rst_rf_we", 32'(bus.rf_we), 32'd0);
        chk("rst_wb1_ready", 32'(bus.wb1_ready), 32'd0);
        chk("rst_busy0", bus.busy, 32'd0);
        chk("rst_stall", 32'(bus.stall_o), 32'd0);
        tick();
        rst = 1'b0;

        // wb0 priority, then wb1 served once the pipeline is idle
        set_in(0, 0, 0, 0, 0, 0, 1, 6); tick();
        set_in(1, 5, 32'hAA, 1, 6, 32'hBB, 1, 7);
        at_neg();
        chk("p29_we", 32'(bus.rf_we), 32'd1);
        chk("p29_wa", 32'(bus.rf_wa), 32'd5);
        chk("p29_wd", bus.rf_wd, 32'hAA);
        chk("p29_ready", 32'(bus.wb1_ready), 32'd0);
        tick();
        set_in(0, 0, 0, 1, 6, 32'hBB, 0, 0);
        at_neg();
        chk("p29b_wa", 32'(bus.rf_wa), 32'd6);
        chk("p29b_wd", bus.rf_wd, 32'hBB);
        chk("p29b_ready", 32'(bus.wb1_ready), 32'd1);
        tick();

        // rd==0 on either side
        set_in(1, 0, 32'h55, 1, 7, 32'h11, 0, 0);
        at_neg();
        chk("p30_we", 32'(bus.rf_we), 32'd1);
        chk("p30_wa", 32'(bus.rf_wa), 32'd7);
        chk("p30_wd", bus.rf_wd, 32'h11);
        chk("p30_ready", 32'(bus.wb1_ready), 32'd1);
        tick();
        set_in(1, 3, 32'h33, 1, 0, 32'h77, 0, 0);
        at_neg();
        chk("p30b_ready", 32'(bus.wb1_ready), 32'd1);
        chk("p30b_wa", 32'(bus.rf_wa), 32'd3);
        chk("p30b_wd", bus.rf_wd, 32'h33);
        tick();

        // scoreboard lifetime of r9
        set_in(0, 0, 0, 0, 0, 0, 1, 9);
        at_neg();
        chk("p31_busy_pre", bus.busy, 32'd0);
        chk("p31_perr_pre", 32'(bus.protocol_err), 32'd0);
        tick();
        for (int i = 0; i < 2; i++) begin
            idle();
            at_neg();
            chk("p31_busy_wait", bus.busy, 32'h200);
            tick();
        end
        set_in(0, 0, 0, 1, 9, 32'h99, 0, 0);
        at_neg();
        chk("p31_busy_hs", bus.busy, 32'h200);
        chk("p31_hs_wa", 32'(bus.rf_wa), 32'd9);
        tick();
        set_in(0, 0, 0, 0, 0, 0, 1, 9);
        at_neg();
        chk("p31_busy_clr", bus.busy, 32'd0);
        tick();
        set_in(0, 0, 0, 1, 9, 32'h9A, 1, 9);
        at_neg();
        chk("p31_same_ready", 32'(bus.wb1_ready), 32'd1);
        tick();
        idle();
        at_neg();
        chk("p31_set_wins", bus.busy, 32'h200);
        chk("p31_reissue_err", 32'(bus.protocol_err), 32'd1);
        tick();
        rst_pulse();

        // double issue without writeback is a protocol error; r0 issues are ignored
        set_in(0, 0, 0, 0, 0, 0, 1, 0); tick();
        idle();
        at_neg();
        chk("p33_r0_busy", bus.busy, 32'd0);
        chk("p33_r0_perr", 32'(bus.protocol_err), 32'd0);
        set_in(0, 0, 0, 0, 0, 0, 1, 4); tick();
        set_in(0, 0, 0, 0, 0, 0, 1, 4); tick();
        idle();
        at_neg();
        chk("p33_perr", 32'(bus.protocol_err), 32'd1);
        chk("p33_busy", bus.busy, 32'h10);
        repeat (2) tick();
        at_neg();
        chk("p33_sticky", 32'(bus.protocol_err), 32'd1);
        tick();
        rst_pulse();

        // starvation: four blocked cycles raise stall, pipeline then yields
        set_in(0, 0, 0, 0, 0, 0, 1, 4); tick();
        set_in(0, 0, 0, 0, 0, 0, 1, 8); tick();
        starve();
        set_in(0, 0, 0, 1, 4, 32'hC4, 0, 0);
        at_neg();
        chk("p32_stall", 32'(bus.stall_o), 32'(GUARD));
        chk("p32_ready", 32'(bus.wb1_ready), 32'd1);
        chk("p32_wa", 32'(bus.rf_wa), 32'd4);
        tick();
        idle();
        at_neg();
        chk("p32_stall_clr", 32'(bus.stall_o), 32'd0);
        chk("p32_busy", bus.busy, 32'h100);
        chk("p32_perr", 32'(bus.protocol_err), 32'd0);
        tick();

        // asynchronous reset in the middle of a stall
        set_in(0, 0, 0, 0, 0, 0, 1, 4); tick();
        starve();
        set_in(0, 0, 0, 1, 4, 32'hC4, 0, 0);
        at_neg();
        chk("p34_stall_pre", 32'(bus.stall_o), 32'(GUARD));
        chk("p34_busy_pre", bus.busy, 32'h110);
        #2 rst = 1'b1;
        #1;
        chk("p34_busy", bus.busy, 32'd0);
        chk("p34_stall", 32'(bus.stall_o), 32'd0);
        chk("p34_we", 32'(bus.rf_we), 32'd0);
        chk("p34_ready", 32'(bus.wb1_ready), 32'd0);
        tick();
        rst = 1'b0;
        idle();
        at_neg();
        chk("p34_after_we", 32'(bus.rf_we), 32'd0);
        chk("p34_after_busy", bus.busy, 32'd0);
        repeat (2) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/rf_write_arbiter.md
RF_WRITE_ARBITER -- requirements
Module: rf_write_arbiter

Interface
REQ-001 Parameter: STARVE_LIMIT, 4, wb1 blocked cycles before a starvation stall is raised (legal 1..15).
REQ-002 Port: clk  in  1  clock; all state updates on rising edge.
REQ-003 Port: rst  in  1  reset, asynchronous, active-high.
REQ-004 Port: wb0_valid / wb0_rd / wb0_data  in  1/5/32  pipeline writeback; no backpressure.
REQ-005 Port: wb1_valid / wb1_rd / wb1_data  in  1/5/32  multicycle-unit writeback request.
REQ-006 Port: wb1_ready  out  1  wb1 accepted this cycle; handshake = wb1_valid & wb1_ready.
REQ-007 Port: iss_valid / iss_rd  in  1/5  multicycle op issued targeting iss_rd.
REQ-008 Port: rf_we / rf_wa / rf_wd  out  1/5/32  register-file write port (WE3/A3/WD3).
REQ-009 Port: busy  out  32  scoreboard; bit n = register n awaits a multicycle result.
REQ-010 Port: stall_o  out  1  pipeline must present wb0_valid=0 next cycle.
REQ-011 Port: protocol_err  out  1  sticky protocol-violation flag.

Function
REQ-012 Grant combinational, same cycle: wb0 with rd!=0 owns the port; otherwise wb1 with rd!=0 owns it; otherwise rf_we=0.
REQ-013 rf_we/rf_wa/rf_wd SHALL carry the owner's valid/rd/data; rf_wa/rf_wd = 0 when rf_we=0.
REQ-014 wb1_ready=1 when wb1_valid and (wb1_rd==0, or wb0 not owning the port); rd==0 requests complete without rf_we.
REQ-015 wb1_ready SHALL be 0 whenever wb1_valid=0.
REQ-016 wait_cnt (4 bit) increments each cycle wb1_valid & !wb1_ready, saturating at 15; clears on wb1 handshake or wb1_valid=0.
REQ-017 busy[iss_rd] set on next edge when iss_valid & iss_rd!=0; busy[wb1_rd] cleared on wb1 handshake.
REQ-018 Set and clear of the same bit in one cycle: set wins.
REQ-019 busy[0] SHALL be constant 0.
REQ-020 protocol_err set (sticky until reset) on: iss_valid to an already-busy rd; wb1 handshake with rd!=0 whose busy bit is 0; wb0_valid & rd!=0 while stall_o=1.
REQ-021 On a REQ-020 violation the port SHALL still follow REQ-012 (wb0 wins).

Reset
REQ-022 While rst=1: busy=0, wait_cnt=0, stall_o=0, protocol_err=0.
REQ-023 While rst=1: rf_we=0 and wb1_ready=0 regardless of inputs.
REQ-024 Reset asserted mid-stall or mid-request SHALL abandon it; no write occurs in or after that cycle until rst=0.

Configuration
REQ-025 Macro RF_ARB_STARVE_GUARD_EN compiles in the starvation guard.
REQ-026 Defined: stall_o registered, set on the edge where wait_cnt==STARVE_LIMIT-1 and wb1 still blocked; cleared on the edge after wb1 handshake or wb1_valid=0.
REQ-027 Defined: while stall_o=1 and wb0_valid=0, wb1 SHALL be granted that cycle.
REQ-028 Not defined: stall_o tied 0, wait_cnt absent, third REQ-020 check removed; wb1 served only when wb0 idle or rd==0.

Verification
REQ-029 wb0(rd=5,D=0xAA) and wb1(rd=6,D=0xBB) same cycle -> rf_we=1, rf_wa=5, rf_wd=0xAA, wb1_ready=0; next cycle wb0 idle -> rf_wa=6, wb1_ready=1.
REQ-030 wb0(rd=0) and wb1(rd=7,D=0x11) -> rf_we=1, rf_wa=7, wb1_ready=1; wb1(rd=0) with wb0(rd=3) -> wb1_ready=1, rf_wa=3.
REQ-031 iss(rd=9), then wb1(rd=9) handshake 3 cycles later -> busy[9]=1 for 3 cycles, 0 after handshake edge; iss(rd=9) + wb1(rd=9) handshake same cycle -> busy[9] stays 1.
REQ-032 Guard on, STARVE_LIMIT=4, wb0 busy every cycle, wb1 valid -> stall_o=1 after 4 blocked cycles; pipeline drops wb0 -> wb1 granted, stall_o=0 next cycle.
REQ-033 iss(rd=4) twice without writeback -> protocol_err=1, stays 1 until rst; iss(rd=0) -> busy unchanged, no error.
REQ-034 rst pulse during stall_o=1 with busy=0x0000_0110 -> busy=0, stall_o=0, rf_we=0 asynchronously.
